tri_walker: RTL and testbench
=============================

// Module: tri_walker
// PURPOSE
//  Consumes one triangle (3 vertices) plus the shade-plane gradients cx/cy/cs from interp.
//  Walks the triangle's bounding box and emits one covered pixel per cycle with interpolated shade.
//  Sits between interp and the framebuffer write stage.
//  Uses valid/ready on both the triangle input and the pixel output.
// PARAMETERS
//  COORD_W  12  vertex / pixel coordinate width (unsigned)
//  ATTR_W   12  shade width (unsigned); output is clamped to [0, 2^ATTR_W-1]
//  GRAD_W   24  gradient width; signed Q(GRAD_W-FRAC).FRAC two's complement
//  FRAC      6  fractional bits of cx/cy/cs
//  ACC_W    40  signed shade accumulator width
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous, active-high reset
//  tri_valid  in   1        triangle and gradients valid
//  tri_ready  out  1        block idle; can accept a triangle
//  x0,y0,x1,y1,x2,y2 in COORD_W  vertices; winding is arbitrary
//  cx,cy,cs   in   GRAD_W   plane s(x,y) = cx*x + cy*y + cs, in Q.FRAC
//  pix_valid  out  1        pixel outputs valid
//  pix_ready  in   1        downstream accepts the pixel
//  pix_x,pix_y out COORD_W  pixel coordinate
//  pix_s      out  ATTR_W   interpolated, rounded, clamped shade
//  tri_done   out  1        1-cycle pulse when the walk completes (also for 0-pixel triangles)
// BEHAVIOUR
//  Reset values: pix_valid=0, tri_done=0, pix_x/pix_y/pix_s=0, state=IDLE.
//  tri_ready = (state==IDLE). It reads 0 while rst is high.
//  FSM: IDLE -> SETUP -> INIT -> WALK -> DONE -> IDLE.
//   IDLE: on tri_valid & tri_ready, register all inputs.
//   SETUP: compute the following.
//    - Bounding box xmin/xmax/ymin/ymax (inclusive).
//    - Edge coefficients a_i=y_j-y_k, b_i=x_k-x_j, c_i=x_j*y_k-x_k*y_j (signed, COORD_W*2+2 bits).
//    - area = c0+c1+c2.
//    If area==0, go directly to DONE (no pixels).
//   INIT: evaluate E_i(xmin,ymin) and acc = cx*xmin + cy*ymin + cs (sign-extended to ACC_W).
//    Also save row-start copies of E_i and acc.
//   WALK: visit each bbox pixel in raster order, row-major, x increasing.
//    - Step x: E_i += a_i; acc += cx.
//    - New row: reload row-start values, add b_i to E_i and cy to acc, then re-save them.
//    - A pixel is inside iff all E_i>=0 or all E_i<=0. Shared edges are included (no top-left rule).
//    - Inside pixels load the output register. Outside pixels cost one cycle and emit nothing.
//    - Leave for DONE after visiting (xmax,ymax) once the output register has drained.
//   DONE: tri_done=1 for exactly one cycle, then go to IDLE.
//  Latency: the first bbox pixel appears on pix_valid 4 cycles after the accept edge, if it is inside.
//  Throughput: 1 visited pixel per cycle while unstalled.
//  Output register handshake:
//   - The walker advances only if !pix_valid or pix_ready.
//   - While pix_valid & !pix_ready, pix_x/pix_y/pix_s hold stable and the walker freezes.
//   - No pixel is dropped or duplicated.
//  Shade: pix_s = clamp((acc + 2^(FRAC-1)) >>> FRAC, 0, 2^ATTR_W-1), using an arithmetic shift.
//  Accumulator arithmetic is wrap-free for 12-bit coordinates with ACC_W=40.
//  Single-pixel triangles are ineligible: they are degenerate (area 0) and emit nothing.
//  Reset mid-walk: state goes to IDLE next cycle; pix_valid=0; the partial triangle is discarded.
//   tri_done is not pulsed.
//  tri_valid arriving outside IDLE is ignored, because tri_ready=0.
// STRUCTURE
//  Shared package raster_pkg contains the following.
//   - coord_t, attr_t, grad_t, edge_t typedefs.
//   - FRAC constant.
//   - walk_state_e enum {IDLE,SETUP,INIT,WALK,DONE}.
//  Sub-module edge_eval does coefficient setup, origin evaluation, and x/row stepping for one edge.
//   It is instantiated three times.
//  The top level holds the FSM, bbox counters, shade accumulator, clamp, and output register.
// TESTING
//  1. Vertices (0,0),(3,0),(0,3); cx=64 (1.0), cy=0, cs=0; pix_ready=1.
//     -> 10 pixels with x+y<=3 in raster order, pix_s==pix_x, then one tri_done pulse.
//  2. Same as test 1, but pix_ready=0 for 5 cycles after the 3rd pixel.
//     -> Outputs stay stable while stalled; the sequence is identical to test 1; no drops or duplicates.
//  3. Collinear vertices (0,0),(2,2),(4,4).
//     -> Zero pix_valid; tri_done 3 cycles after accept; tri_ready=1 the next cycle.
//  4. Test 1 triangle with cx=cy=0.
//     -> cs=-640: all pix_s=0.
//     -> cs=64*5000: all pix_s=4095.
//     -> cs=96 (1.5): pix_s=2 (round half up).
//  5. Vertices (0,0),(0,3),(3,0), i.e. CW winding.
//     -> The same 10-pixel set as test 1.
//  6. Assert rst during WALK after 2 pixels, then send a new triangle.
//     -> pix_valid=0 the next cycle; no tri_done for the aborted triangle.
//     -> The new triangle is walked correctly from its first pixel.

Source files
------------

// File: rtl/tri_walker_pkg.sv
// Shared types, constants and small arithmetic helpers for the triangle walker.
package raster_pkg;

    localparam int COORD_W = 12;
    localparam int ATTR_W  = 12;
    localparam int GRAD_W  = 24;
    localparam int FRAC    = 6;
    localparam int ACC_W   = 40;
    localparam int EDGE_W  = COORD_W * 2 + 2;

    typedef logic        [COORD_W-1:0] coord_t;
    typedef logic        [ATTR_W-1:0]  attr_t;
    typedef logic signed [GRAD_W-1:0]  grad_t;
    typedef logic signed [EDGE_W-1:0]  edge_t;
    typedef logic signed [ACC_W-1:0]   acc_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        INIT  = 3'd2,
        WALK  = 3'd3,
        DONE  = 3'd4
    } walk_state_e;

    localparam coord_t COORD_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam acc_t   SHADE_RND  = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam acc_t   SHADE_MAX  = {{(ACC_W-ATTR_W){1'b0}}, {ATTR_W{1'b1}}};

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return m;
    endfunction

    function automatic acc_t acc_ext(input coord_t v);
        return {{(ACC_W-COORD_W){1'b0}}, v};
    endfunction

    // Round half up in Q.FRAC, then saturate to the unsigned shade range.
    function automatic attr_t shade_clamp(input acc_t acc);
        acc_t  sum_s;
        acc_t  shf_s;
        attr_t res_s;
        sum_s = acc + SHADE_RND;
        shf_s = sum_s >>> FRAC;
        if (shf_s[ACC_W-1]) begin
            res_s = '0;
        end else if (shf_s > SHADE_MAX) begin
            res_s = '1;
        end else begin
            res_s = shf_s[ATTR_W-1:0];
        end
        return res_s;
    endfunction

endpackage

// File: rtl/tri_walker_if.sv
// Triangle-in / pixel-out handshake bundle of the triangle walker.
interface tri_walker_if;
    import raster_pkg::*;

    logic   tri_valid;
    logic   tri_ready;
    coord_t x0, y0, x1, y1, x2, y2;
    grad_t  cx, cy, cs;
    logic   pix_valid;
    logic   pix_ready;
    coord_t pix_x, pix_y;
    attr_t  pix_s;
    logic   tri_done;

    modport master (
        output tri_valid, x0, y0, x1, y1, x2, y2, cx, cy, cs, pix_ready,
        input  tri_ready, pix_valid, pix_x, pix_y, pix_s, tri_done
    );

    modport slave (
        input  tri_valid, x0, y0, x1, y1, x2, y2, cx, cy, cs, pix_ready,
        output tri_ready, pix_valid, pix_x, pix_y, pix_s, tri_done
    );

endinterface

// File: rtl/tri_walker_edge_eval.sv
// One edge function E(x,y) = a*x + b*y + c: coefficient setup, origin evaluation
// and incremental x / row stepping across the bounding box.
module edge_eval
    import raster_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   init,
    input  logic   step_x,
    input  logic   step_row,
    input  coord_t xj,
    input  coord_t yj,
    input  coord_t xk,
    input  coord_t yk,
    input  coord_t xmin,
    input  coord_t ymin,
    output edge_t  c_coef,
    output edge_t  e_val
);

    function automatic edge_t ext(input coord_t v);
        return {{(EDGE_W-COORD_W){1'b0}}, v};
    endfunction

    edge_t a_r, b_r, c_r;
    edge_t e_r, e_row_r;
    edge_t a_s, b_s, c_s, orig_s;

    assign a_s    = ext(yj) - ext(yk);
    assign b_s    = ext(xk) - ext(xj);
    assign c_s    = ext(xj) * ext(yk) - ext(xk) * ext(yj);
    assign orig_s = a_r * ext(xmin) + b_r * ext(ymin) + c_r;

    assign c_coef = c_s;
    assign e_val  = e_r;

    // Coefficient registers plus the running and row-start edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= '0;
            e_r     <= '0;
            e_row_r <= '0;
        end else begin
            if (load) begin
                a_r <= a_s;
                b_r <= b_s;
                c_r <= c_s;
            end
            if (init) begin
                e_r     <= orig_s;
                e_row_r <= orig_s;
            end else if (step_row) begin
                e_r     <= e_row_r + b_r;
                e_row_r <= e_row_r + b_r;
            end else if (step_x) begin
                e_r <= e_r + a_r;
            end
        end
    end

endmodule

// File: rtl/tri_walker.sv
// Triangle walker: scans the bounding box of one triangle in raster order and
// emits each covered pixel with its plane-interpolated, rounded, clamped shade.
module tri_walker
    import raster_pkg::*;
(
    input logic         clk,
    input logic         rst,
    tri_walker_if.slave bus
);

    walk_state_e state_r, state_s;

    coord_t vx_r [3];
    coord_t vy_r [3];
    grad_t  cx_r, cy_r, cs_r;
    coord_t xmin_r, xmax_r, ymin_r, ymax_r;
    coord_t cur_x_r, cur_y_r;
    acc_t   acc_r, acc_row_r;
    logic   area_zero_r;
    logic   walk_end_r;

    logic   pix_valid_r;
    coord_t pix_x_r, pix_y_r;
    attr_t  pix_s_r;
    logic   tri_done_r;

    edge_t  e_val_s  [3];
    edge_t  c_coef_s [3];
    edge_t  area_s;
    acc_t   acc_orig_s;
    logic   tri_ready_s, accept_s, advance_s;
    logic   row_end_s, last_s, step_x_s, step_row_s;
    logic   all_pos_s, all_neg_s, inside_s;

    assign tri_ready_s = (state_r == IDLE) && !rst;
    assign accept_s    = bus.tri_valid && tri_ready_s;
    assign advance_s   = (state_r == WALK) && !walk_end_r && (!pix_valid_r || bus.pix_ready);
    assign row_end_s   = (cur_x_r == xmax_r);
    assign last_s      = row_end_s && (cur_y_r == ymax_r);
    assign step_x_s    = advance_s && !row_end_s;
    assign step_row_s  = advance_s && row_end_s && !last_s;

    assign area_s     = c_coef_s[0] + c_coef_s[1] + c_coef_s[2];
    assign acc_orig_s = acc_t'(cx_r) * acc_ext(xmin_r) + acc_t'(cy_r) * acc_ext(ymin_r) + acc_t'(cs_r);

    // Either winding counts; pixels exactly on an edge are covered.
    assign all_pos_s = !e_val_s[0][EDGE_W-1] && !e_val_s[1][EDGE_W-1] && !e_val_s[2][EDGE_W-1];
    assign all_neg_s = (e_val_s[0][EDGE_W-1] || (e_val_s[0] == '0)) &&
                       (e_val_s[1][EDGE_W-1] || (e_val_s[1] == '0)) &&
                       (e_val_s[2][EDGE_W-1] || (e_val_s[2] == '0));
    assign inside_s  = all_pos_s || all_neg_s;

    // Edge i is formed by vertices (i+1)%3 and (i+2)%3.
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        edge_eval u_edge (
            .clk      (clk),
            .rst      (rst),
            .load     (state_r == SETUP),
            .init     (state_r == INIT),
            .step_x   (step_x_s),
            .step_row (step_row_s),
            .xj       (vx_r[(gi+1)%3]),
            .yj       (vy_r[(gi+1)%3]),
            .xk       (vx_r[(gi+2)%3]),
            .yk       (vy_r[(gi+2)%3]),
            .xmin     (xmin_r),
            .ymin     (ymin_r),
            .c_coef   (c_coef_s[gi]),
            .e_val    (e_val_s[gi])
        );
    end

    // Walk sequencing; the area test resolves in INIT from the registered area flag.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: state_s = INIT;
            INIT: begin
                if (area_zero_r) begin
                    state_s = DONE;
                end else begin
                    state_s = WALK;
                end
            end
            WALK: begin
                if (walk_end_r && (!pix_valid_r || bus.pix_ready)) begin
                    state_s = DONE;
                end else begin
                    state_s = WALK;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            tri_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            tri_done_r <= (state_s == DONE);
        end
    end

    // Input capture, bounding box, raster counters and shade accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                vx_r[i] <= '0;
                vy_r[i] <= '0;
            end
            cx_r        <= '0;
            cy_r        <= '0;
            cs_r        <= '0;
            xmin_r      <= '0;
            xmax_r      <= '0;
            ymin_r      <= '0;
            ymax_r      <= '0;
            cur_x_r     <= '0;
            cur_y_r     <= '0;
            acc_r       <= '0;
            acc_row_r   <= '0;
            area_zero_r <= 1'b0;
            walk_end_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                vx_r[0] <= bus.x0;
                vy_r[0] <= bus.y0;
                vx_r[1] <= bus.x1;
                vy_r[1] <= bus.y1;
                vx_r[2] <= bus.x2;
                vy_r[2] <= bus.y2;
                cx_r    <= bus.cx;
                cy_r    <= bus.cy;
                cs_r    <= bus.cs;
            end
            if (state_r == SETUP) begin
                xmin_r      <= min3(vx_r[0], vx_r[1], vx_r[2]);
                xmax_r      <= max3(vx_r[0], vx_r[1], vx_r[2]);
                ymin_r      <= min3(vy_r[0], vy_r[1], vy_r[2]);
                ymax_r      <= max3(vy_r[0], vy_r[1], vy_r[2]);
                area_zero_r <= (area_s == '0);
            end
            if (state_r == INIT) begin
                cur_x_r    <= xmin_r;
                cur_y_r    <= ymin_r;
                acc_r      <= acc_orig_s;
                acc_row_r  <= acc_orig_s;
                walk_end_r <= 1'b0;
            end else if (advance_s) begin
                if (last_s) begin
                    walk_end_r <= 1'b1;
                end else if (row_end_s) begin
                    cur_x_r   <= xmin_r;
                    cur_y_r   <= cur_y_r + COORD_ONE;
                    acc_r     <= acc_row_r + acc_t'(cy_r);
                    acc_row_r <= acc_row_r + acc_t'(cy_r);
                end else begin
                    cur_x_r <= cur_x_r + COORD_ONE;
                    acc_r   <= acc_r + acc_t'(cx_r);
                end
            end
        end
    end

    // Output register: loads on covered visits, holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_r <= 1'b0;
            pix_x_r     <= '0;
            pix_y_r     <= '0;
            pix_s_r     <= '0;
        end else if (advance_s) begin
            pix_valid_r <= inside_s;
            if (inside_s) begin
                pix_x_r <= cur_x_r;
                pix_y_r <= cur_y_r;
                pix_s_r <= shade_clamp(acc_r);
            end
        end else if (bus.pix_ready) begin
            pix_valid_r <= 1'b0;
        end
    end

    assign bus.tri_ready = tri_ready_s;
    assign bus.pix_valid = pix_valid_r;
    assign bus.pix_x     = pix_x_r;
    assign bus.pix_y     = pix_y_r;
    assign bus.pix_s     = pix_s_r;
    assign bus.tri_done  = tri_done_r;

endmodule

// File: tb/tb_tri_walker.sv
// Directed, table-driven bench for tri_walker with hand-computed pixel lists.
module tb_tri_walker;
    import raster_pkg::*;

    typedef struct {
        logic [11:0]        x0, y0, x1, y1, x2, y2;
        logic signed [23:0] cx, cy, cs;
        int                 stall_after;
        int                 exp_n;
        int                 s_mode;
        int                 s_val;
    } tri_vec_t;

    typedef struct {
        int x;
        int y;
    } xy_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tri_walker_if bus ();

    tri_walker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int failed = 0;

    tri_vec_t vecs [7];
    xy_t      exp_pix [10];

    int got_x[$];
    int got_y[$];
    int got_s[$];
    int first_cyc, done_cyc, n_done, ready_after_done;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_tri(input tri_vec_t v);
        int guard;
        guard = 0;
        while (!bus.tri_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("tri_ready_before_send", bus.tri_ready, 1);
        bus.x0 = v.x0; bus.y0 = v.y0;
        bus.x1 = v.x1; bus.y1 = v.y1;
        bus.x2 = v.x2; bus.y2 = v.y2;
        bus.cx = v.cx; bus.cy = v.cy; bus.cs = v.cs;
        bus.tri_valid = 1'b1;
        @(negedge clk);
        bus.tri_valid = 1'b0;
    endtask

    // Collects pixels cycle by cycle; cycle 1 is the first cycle after the accept edge.
    task automatic run_tri(input tri_vec_t v, input string name);
        int stall_left;
        bit have_hold;
        int hx, hy, hs;
        got_x.delete(); got_y.delete(); got_s.delete();
        first_cyc = -1; done_cyc = -1; n_done = 0; ready_after_done = -1;
        stall_left = 0; have_hold = 0; hx = 0; hy = 0; hs = 0;
        bus.pix_ready = 1'b1;
        drive_tri(v);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (stall_left > 0) begin
                bus.pix_ready = 1'b0;
                stall_left--;
            end else begin
                bus.pix_ready = 1'b1;
            end
            if (bus.pix_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (!bus.pix_ready) begin
                    if (have_hold) begin
                        check({name, "_stall_x"}, bus.pix_x, hx);
                        check({name, "_stall_y"}, bus.pix_y, hy);
                        check({name, "_stall_s"}, bus.pix_s, hs);
                    end else begin
                        hx = bus.pix_x; hy = bus.pix_y; hs = bus.pix_s;
                        have_hold = 1;
                    end
                end else begin
                    have_hold = 0;
                    got_x.push_back(bus.pix_x);
                    got_y.push_back(bus.pix_y);
                    got_s.push_back(bus.pix_s);
                    if (got_x.size() == v.stall_after) stall_left = 5;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) ready_after_done = bus.tri_ready;
            if (bus.tri_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
        bus.pix_ready = 1'b1;
    endtask

    task automatic compare_run(input tri_vec_t v, input string name);
        int n;
        int es;
        check({name, "_done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
        check({name, "_n_pix"}, got_x.size(), v.exp_n);
        n = (got_x.size() < v.exp_n) ? got_x.size() : v.exp_n;
        for (int i = 0; i < n; i++) begin
            es = (v.s_mode == 0) ? exp_pix[i].x : v.s_val;
            check($sformatf("%s_x[%0d]", name, i), got_x[i], exp_pix[i].x);
            check($sformatf("%s_y[%0d]", name, i), got_y[i], exp_pix[i].y);
            check($sformatf("%s_s[%0d]", name, i), got_s[i], es);
        end
        check({name, "_done_pulses"}, n_done, 1);
        check({name, "_ready_after_done"}, ready_after_done, 1);
        if (v.exp_n > 0) begin
            check({name, "_first_latency"}, first_cyc, 4);
        end else begin
            check({name, "_done_latency"}, done_cyc, 3);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int accepted;
        int done_seen;
        int valid_seen;

        exp_pix[0] = '{0, 0}; exp_pix[1] = '{1, 0}; exp_pix[2] = '{2, 0}; exp_pix[3] = '{3, 0};
        exp_pix[4] = '{0, 1}; exp_pix[5] = '{1, 1}; exp_pix[6] = '{2, 1};
        exp_pix[7] = '{0, 2}; exp_pix[8] = '{1, 2};
        exp_pix[9] = '{0, 3};

        //          x0     y0     x1     y1     x2     y2     cx       cy      cs              stall n   mode sval
        vecs[0] = '{12'd0, 12'd0, 12'd3, 12'd0, 12'd0, 12'd3, 24'sd64, 24'sd0, 24'sd0,         -1,  10, 0,   0};
        vecs[1] = '{12'd0, 12'd0, 12'd3, 12'd0, 12'd0, 12'd3, 24'sd64, 24'sd0, 24'sd0,          3,  10, 0,   0};
        vecs[2] = '{12'd0, 12'd0, 12'd2, 12'd2, 12'd4, 12'd4, 24'sd64, 24'sd0, 24'sd0,         -1,   0, 0,   0};
        vecs[3] = '{12'd0, 12'd0, 12'd3, 12'd0, 12'd0, 12'd3, 24'sd0,  24'sd0, -24'sd640,      -1,  10, 1,   0};
        vecs[4] = '{12'd0, 12'd0, 12'd3, 12'd0, 12'd0, 12'd3, 24'sd0,  24'sd0, 24'sd320000,    -1,  10, 1,   4095};
        vecs[5] = '{12'd0, 12'd0, 12'd3, 12'd0, 12'd0, 12'd3, 24'sd0,  24'sd0, 24'sd96,        -1,  10, 1,   2};
        vecs[6] = '{12'd0, 12'd0, 12'd0, 12'd3, 12'd3, 12'd0, 24'sd64, 24'sd0, 24'sd0,         -1,  10, 0,   0};

        bus.tri_valid = 1'b0;
        bus.pix_ready = 1'b1;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
        bus.cx = '0; bus.cy = '0; bus.cs = '0;

        repeat (3) @(negedge clk);
        check("reset_tri_ready", bus.tri_ready, 0);
        check("reset_pix_valid", bus.pix_valid, 0);
        check("reset_tri_done", bus.tri_done, 0);
        check("reset_pix_x", bus.pix_x, 0);
        check("reset_pix_y", bus.pix_y, 0);
        check("reset_pix_s", bus.pix_s, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tri_ready", bus.tri_ready, 1);

        for (int t = 0; t < 7; t++) begin
            run_tri(vecs[t], $sformatf("vec%0d", t));
            compare_run(vecs[t], $sformatf("vec%0d", t));
        end

        // Abort a walk after two accepted pixels, then walk a fresh triangle.
        bus.pix_ready = 1'b1;
        drive_tri(vecs[0]);
        accepted = 0;
        for (int cyc = 0; cyc < 40 && accepted < 2; cyc++) begin
            if (bus.pix_valid) accepted++;
            @(negedge clk);
        end
        check("abort_two_pixels", accepted, 2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_pix_valid", bus.pix_valid, 0);
        check("abort_tri_ready_in_rst", bus.tri_ready, 0);
        check("abort_tri_done_in_rst", bus.tri_done, 0);
        rst = 1'b0;
        done_seen = 0;
        valid_seen = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (bus.tri_done) done_seen++;
            if (bus.pix_valid) valid_seen++;
        end
        check("abort_no_tri_done", done_seen, 0);
        check("abort_no_pix_valid", valid_seen, 0);
        run_tri(vecs[6], "after_abort");
        compare_run(vecs[6], "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
